// File: rtl/mfp_adc_max10_avg.sv
// Per-channel boxcar averager between the MAX10 ADC response port and the ADC core.
// Define ADC_AVG_ROUND_EN to round to nearest (with saturation) instead of truncating.
module mfp_adc_max10_avg #(
    parameter int AVG_LOG2 = 2
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        AVG_Clear,
    input  logic        IN_Valid,
    input  logic [4:0]  IN_Channel,
    input  logic [11:0] IN_Data,
    input  logic        IN_SOP,
    input  logic        IN_EOP,
    output logic        OUT_Valid,
    output logic [4:0]  OUT_Channel,
    output logic [11:0] OUT_Data,
    output logic        OUT_SOP,
    output logic        OUT_EOP
);

    localparam int NCH = 32;
    localparam int AW  = 12 + AVG_LOG2;
    // A zero-width counter is illegal, so AVG_LOG2=0 keeps a 1-bit counter that never leaves 0.
    localparam int CW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0] acc_q [NCH];
    logic [CW-1:0] cnt_q [NCH];

    logic          out_valid_q;
    logic [4:0]    out_channel_q;
    logic [11:0]   out_data_q;
    logic          out_sop_q;
    logic          out_eop_q;

    logic [AW-1:0] acc_rd;
    logic [CW-1:0] cnt_rd;
    logic [AW-1:0] sum_w;
    logic          last_w;
    logic [AW-1:0] acc_d;
    logic [CW-1:0] cnt_d;
    logic [11:0]   avg_w;

    always_comb begin
        acc_rd = acc_q[IN_Channel];
        cnt_rd = cnt_q[IN_Channel];
        sum_w  = acc_rd + AW'(IN_Data);
        last_w = (cnt_rd == CNT_LAST);
        acc_d  = last_w ? '0 : sum_w;
        cnt_d  = last_w ? '0 : cnt_rd + CW'(1);
    end

`ifdef ADC_AVG_ROUND_EN
    localparam logic [AW:0] RND = (AW+1)'((1 << AVG_LOG2) >> 1);
    logic [AW:0] rnd_w;
    logic [AW:0] shifted_w;

    always_comb begin
        rnd_w     = {1'b0, sum_w} + RND;
        shifted_w = rnd_w >> AVG_LOG2;
        avg_w     = (shifted_w > (AW+1)'(4095)) ? 12'hFFF : 12'(shifted_w);
    end
`else
    // The full window sum fits in AW bits, so the shifted value always fits in 12.
    always_comb begin
        avg_w = 12'(sum_w >> AVG_LOG2);
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_data_q    <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (AVG_Clear) begin
                for (int i = 0; i < NCH; i++) begin
                    acc_q[i] <= '0;
                    cnt_q[i] <= '0;
                end
            end else if (IN_Valid) begin
                acc_q[IN_Channel] <= acc_d;
                cnt_q[IN_Channel] <= cnt_d;
                if (last_w) begin
                    out_valid_q   <= 1'b1;
                    out_channel_q <= IN_Channel;
                    out_data_q    <= avg_w;
                    out_sop_q     <= IN_SOP;
                    out_eop_q     <= IN_EOP;
                end
            end
        end
    end

    assign OUT_Valid   = out_valid_q;
    assign OUT_Channel = out_channel_q;
    assign OUT_Data    = out_data_q;
    assign OUT_SOP     = out_sop_q;
    assign OUT_EOP     = out_eop_q;

endmodule

// File: tb/tb_mfp_adc_max10_avg.sv
// Bench for mfp_adc_max10_avg: AVG_LOG2=2 and AVG_LOG2=0 instances share one stimulus stream
// and are both compared every cycle against a queue-based window model.
module tb_mfp_adc_max10_avg;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        AVG_Clear;
    logic        IN_Valid;
    logic [4:0]  IN_Channel;
    logic [11:0] IN_Data;
    logic        IN_SOP;
    logic        IN_EOP;

    logic        a_valid, z_valid;
    logic [4:0]  a_ch, z_ch;
    logic [11:0] a_data, z_data;
    logic        a_sop, z_sop, a_eop, z_eop;

    always #5 CLK = ~CLK;

    mfp_adc_max10_avg #(.AVG_LOG2(2)) dut_avg4 (
        .CLK(CLK), .RESETn(RESETn), .AVG_Clear(AVG_Clear), .IN_Valid(IN_Valid),
        .IN_Channel(IN_Channel), .IN_Data(IN_Data), .IN_SOP(IN_SOP), .IN_EOP(IN_EOP),
        .OUT_Valid(a_valid), .OUT_Channel(a_ch), .OUT_Data(a_data),
        .OUT_SOP(a_sop), .OUT_EOP(a_eop)
    );

    mfp_adc_max10_avg #(.AVG_LOG2(0)) dut_avg1 (
        .CLK(CLK), .RESETn(RESETn), .AVG_Clear(AVG_Clear), .IN_Valid(IN_Valid),
        .IN_Channel(IN_Channel), .IN_Data(IN_Data), .IN_SOP(IN_SOP), .IN_EOP(IN_EOP),
        .OUT_Valid(z_valid), .OUT_Channel(z_ch), .OUT_Data(z_data),
        .OUT_SOP(z_sop), .OUT_EOP(z_eop)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: per instance, per channel list of samples in the open window,
    // plus the last output beat (outputs hold when nothing completes).
    int win_q [2][32][$];
    int e_valid [2];
    int e_ch    [2];
    int e_data  [2];
    int e_sop   [2];
    int e_eop   [2];
    int log2_of [2] = '{2, 0};

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_avg(input int lg, input int sum);
        int r;
`ifdef ADC_AVG_ROUND_EN
        r = (lg > 0) ? (sum + (1 << (lg - 1))) / (1 << lg) : sum;
        if (r > 4095) r = 4095;
`else
        r = sum / (1 << lg);
`endif
        return r;
    endfunction

    task automatic step(input bit rst_n, input bit clr, input bit v, input int ch,
                        input int data, input bit sop, input bit eop);
        int sum;
        RESETn     = rst_n;
        AVG_Clear  = clr;
        IN_Valid   = v;
        IN_Channel = 5'(ch);
        IN_Data    = 12'(data);
        IN_SOP     = sop;
        IN_EOP     = eop;
        @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            e_valid[k] = 0;
            if (!rst_n) begin
                for (int c = 0; c < 32; c++) win_q[k][c].delete();
                e_ch[k] = 0; e_data[k] = 0; e_sop[k] = 0; e_eop[k] = 0;
            end else if (clr) begin
                for (int c = 0; c < 32; c++) win_q[k][c].delete();
            end else if (v) begin
                win_q[k][ch].push_back(data);
                if (win_q[k][ch].size() == (1 << log2_of[k])) begin
                    sum = 0;
                    foreach (win_q[k][ch][i]) sum += win_q[k][ch][i];
                    win_q[k][ch].delete();
                    e_valid[k] = 1;
                    e_ch[k]    = ch;
                    e_data[k]  = model_avg(log2_of[k], sum);
                    e_sop[k]   = sop;
                    e_eop[k]   = eop;
                end
            end
        end
        if (e_valid[0] != 0)
            $display("beat avg4: ch=%0d data=%0d sop=%0d eop=%0d t=%0t",
                     e_ch[0], e_data[0], e_sop[0], e_eop[0], $time);
        check_eq("avg4_valid", int'(a_valid), e_valid[0]);
        check_eq("avg4_ch",    int'(a_ch),    e_ch[0]);
        check_eq("avg4_data",  int'(a_data),  e_data[0]);
        check_eq("avg4_sop",   int'(a_sop),   e_sop[0]);
        check_eq("avg4_eop",   int'(a_eop),   e_eop[0]);
        check_eq("avg1_valid", int'(z_valid), e_valid[1]);
        check_eq("avg1_ch",    int'(z_ch),    e_ch[1]);
        check_eq("avg1_data",  int'(z_data),  e_data[1]);
        check_eq("avg1_sop",   int'(z_sop),   e_sop[1]);
        check_eq("avg1_eop",   int'(z_eop),   e_eop[1]);
    endtask

    task automatic beat(input int ch, input int data);
        step(1'b1, 1'b0, 1'b1, ch, data, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int il_data [8] = '{10, 200, 20, 200, 30, 200, 40, 200};
        int ch, data;
        bit rst_n, clr, v;

        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 3, 77, 1'b1, 1'b1);
        idle(2);

        // ch3 window 100..103
        for (int i = 0; i < 4; i++) beat(3, 100 + i);
`ifdef ADC_AVG_ROUND_EN
        check_eq("ch3_avg_const", int'(a_data), 102);
`else
        check_eq("ch3_avg_const", int'(a_data), 101);
`endif
        idle(1);

        // interleaved ch1/ch2
        for (int i = 0; i < 8; i++) beat((i % 2 == 0) ? 1 : 2, il_data[i]);
        idle(1);

        // full-scale samples must not overflow
        for (int i = 0; i < 4; i++) beat(0, 4095);
        check_eq("fullscale_const", int'(a_data), 4095);
        idle(1);

        // clear discards partial window and the coincident beat
        beat(5, 8); beat(5, 8);
        step(1'b1, 1'b1, 1'b1, 5, 8, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) beat(5, 4);
        check_eq("clear_const", int'(a_data), 4);
        idle(1);

        // reset mid-window
        beat(7, 1000); beat(7, 1000);
        step(1'b0, 1'b0, 1'b1, 7, 1000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) beat(7, 0);
        idle(1);

        // back-to-back pass-through on ch31 with packet markers
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 31, i, 1'b1, 1'b1);
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            clr   = ($urandom_range(0, 149) == 0);
            v     = ($urandom_range(0, 3) != 0);
            ch    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                                 : int'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: data = 4095;
                1: data = 0;
                default: data = int'($urandom_range(0, 4095));
            endcase
            step(rst_n, clr, v, ch, data, 1'($urandom), 1'($urandom));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mfp_adc_max10_avg.md
MFP_ADC_MAX10_AVG -- requirements
Module: mfp_adc_max10_avg

Interface
REQ-001 Parameter AVG_LOG2, default 2, log2 of samples averaged per channel window; legal range 0..4.
REQ-002 CLK  input  1  single clock for all logic; all state changes on its rising edge.
REQ-003 RESETn  input  1  reset, synchronous and active-low.
REQ-004 AVG_Clear  input  1  synchronous discard of every partial window.
REQ-005 IN_Valid  input  1  raw ADC response beat valid; no ready exists, so a beat is accepted in every cycle IN_Valid=1.
REQ-006 IN_Channel  input  5  channel of the raw beat.
REQ-007 IN_Data  input  12  raw sample, unsigned.
REQ-008 IN_SOP / IN_EOP  input  1 each  packet markers of the raw beat.
REQ-009 OUT_Valid  output  1  averaged beat valid, one-cycle pulse per beat.
REQ-010 OUT_Channel  output  5  channel of the averaged beat.
REQ-011 OUT_Data  output  12  averaged sample.
REQ-012 OUT_SOP / OUT_EOP  output  1 each  markers of the averaged beat.

Function
REQ-013 The block SHALL sit between the MAX10 ADC response port and the ADC core response inputs, with no backpressure in either direction.
REQ-014 Per channel (32 entries) the block SHALL hold an accumulator of 12+AVG_LOG2 bits and a window counter of AVG_LOG2 bits.
REQ-015 On an accepted beat with counter[ch] < 2^AVG_LOG2-1, the block SHALL add IN_Data to acc[ch], increment counter[ch], and hold OUT_Valid=0 in the next cycle.
REQ-016 On an accepted beat with counter[ch] = 2^AVG_LOG2-1, the block SHALL, in the next cycle, present OUT_Valid=1, OUT_Channel=ch and OUT_Data=(acc[ch]+IN_Data)>>AVG_LOG2, and set acc[ch] and counter[ch] to 0.
REQ-017 The latency from the completing input beat to OUT_Valid SHALL be exactly 1 cycle; back-to-back completing beats SHALL produce back-to-back output beats.
REQ-018 OUT_SOP and OUT_EOP SHALL equal IN_SOP and IN_EOP of the completing beat, registered alongside OUT_Data.
REQ-019 Channels SHALL be independent; interleaved beats of different channels SHALL NOT disturb each other's windows.
REQ-020 The sum SHALL be computed at full width with no overflow; OUT_Data SHALL never exceed 4095.
REQ-021 With AVG_LOG2=0, every accepted beat SHALL pass through with 1-cycle latency and unchanged data.
REQ-022 AVG_Clear=1 SHALL zero all accumulators and counters at the next edge; a beat arriving in the same cycle SHALL be discarded, and OUT_Valid SHALL be 0 in the following cycle.
REQ-023 When IN_Valid=0, OUT_Valid SHALL be 0 in the next cycle, and OUT_Channel, OUT_Data, OUT_SOP and OUT_EOP SHALL hold their last values.

Reset
REQ-024 While RESETn=0 at a clock edge, the block SHALL set all accumulators and counters to 0 and set OUT_Valid, OUT_Channel, OUT_Data, OUT_SOP and OUT_EOP to 0.
REQ-025 Beats presented while RESETn=0 SHALL be discarded; a window interrupted by reset SHALL restart from an empty window.

Configuration
REQ-026 With macro ADC_AVG_ROUND_EN defined, the averaged output SHALL be (sum + 2^(AVG_LOG2-1)) >> AVG_LOG2, saturated to 4095; for AVG_LOG2=0, no rounding term is added.
REQ-027 Without ADC_AVG_ROUND_EN, the averaged output SHALL be sum >> AVG_LOG2 (truncation), and the rounding adder SHALL NOT be present.

Verification
REQ-028 AVG_LOG2=2, ch3 beats with data 100, 101, 102, 103 -> after the 4th beat, a single OUT_Valid pulse with channel 3 and data 101 (truncate) or 102 (ADC_AVG_ROUND_EN).
REQ-029 AVG_LOG2=2, beats interleaved ch1=10, ch2=200, ch1=20, ch2=200, ch1=30, ch2=200, ch1=40, ch2=200 -> output ch1=25, then ch2=200, each 1 cycle after its 4th beat.
REQ-030 AVG_LOG2=2, four ch0 beats of 4095 -> output 4095 with both macro settings.
REQ-031 AVG_LOG2=2, ch5 beats 8, 8, then AVG_Clear=1 together with a third beat, then 4, 4, 4, 4 -> exactly one output, ch5=4.
REQ-032 AVG_LOG2=2, ch7 beats 1000, 1000, then RESETn=0 for 1 cycle, then 0, 0, 0, 0 -> all outputs 0 during reset, then exactly one output, ch7=0.
REQ-033 AVG_LOG2=0, 8 consecutive beats of 0..7 on ch31 with SOP=EOP=1 -> 8 consecutive outputs with data 0..7, SOP=EOP=1, 1-cycle latency.
